acc_unit: RTL and testbench

Parametrised next-generation accumulator for the RetroSoC datapath. It adds configurable data width, a full opcode set (load, inc/dec, add/sub, logic, multi-cycle shifts, clear), status flags, an optional saturating mode and an op_rdy/op_done handshake. It sits between the instruction decoder, which drives opcode, op_rdy and acc_data_in, and the register/bus mux, which consumes acc_out and the flags.

---
 rtl/acc_pkg.sv | 76 +++++++
 rtl/acc_if.sv | 36 +++
 rtl/acc_alu.sv | 66 ++++++
 rtl/acc_unit.sv | 124 ++++++++++++
 tb/tb_acc_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// ============================================================================
// Module  : acc_pkg
// Brief   : Opcodes, ALU op/state encodings and flag indices for acc_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package acc_pkg;

    localparam int OP_W = 24;

    localparam logic [OP_W-1:0] OP_LDA = 24'h888800;
    localparam logic [OP_W-1:0] OP_INC = 24'h888801;
    localparam logic [OP_W-1:0] OP_DEC = 24'h888802;
    localparam logic [OP_W-1:0] OP_ADD = 24'h888803;
    localparam logic [OP_W-1:0] OP_SUB = 24'h888804;
    localparam logic [OP_W-1:0] OP_AND = 24'h888805;
    localparam logic [OP_W-1:0] OP_OR  = 24'h888806;
    localparam logic [OP_W-1:0] OP_XOR = 24'h888807;
    localparam logic [OP_W-1:0] OP_SHL = 24'h888808;
    localparam logic [OP_W-1:0] OP_SHR = 24'h888809;
    localparam logic [OP_W-1:0] OP_CLR = 24'h88880A;

    typedef enum logic [3:0] {
        ALU_LDA = 4'd0,
        ALU_INC = 4'd1,
        ALU_DEC = 4'd2,
        ALU_ADD = 4'd3,
        ALU_SUB = 4'd4,
        ALU_AND = 4'd5,
        ALU_OR  = 4'd6,
        ALU_XOR = 4'd7,
        ALU_SHL = 4'd8,
        ALU_SHR = 4'd9,
        ALU_CLR = 4'd10,
        ALU_ILL = 4'd15
    } alu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

    // Compared zero-extended so an opcode bus wider than 24 bits never aliases.
    function automatic alu_op_e decode_op(input logic [31:0] code);
        alu_op_e op;
        case (code)
            32'(OP_LDA): op = ALU_LDA;
            32'(OP_INC): op = ALU_INC;
            32'(OP_DEC): op = ALU_DEC;
            32'(OP_ADD): op = ALU_ADD;
            32'(OP_SUB): op = ALU_SUB;
            32'(OP_AND): op = ALU_AND;
            32'(OP_OR):  op = ALU_OR;
            32'(OP_XOR): op = ALU_XOR;
            32'(OP_SHL): op = ALU_SHL;
            32'(OP_SHR): op = ALU_SHR;
            32'(OP_CLR): op = ALU_CLR;
            default:     op = ALU_ILL;
        endcase
        return op;
    endfunction

    function automatic logic is_shift(input alu_op_e op);
        return (op == ALU_SHL) || (op == ALU_SHR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_if.sv
// ============================================================================
// Module  : acc_if
// Brief   : Decoder <-> accumulator bus: op handshake, operand, result, flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface acc_if #(
    parameter int DATA_W   = 8,
    parameter int OPCODE_W = 24
);
    logic                acc_en;
    logic [OPCODE_W-1:0] opcode;
    logic                op_rdy;
    logic [DATA_W-1:0]   acc_data_in;
    logic [DATA_W-1:0]   acc_out;
    logic                busy;
    logic                op_done;
    logic                flag_z;
    logic                flag_n;
    logic                flag_c;
    logic                flag_v;
    logic                illegal_op;

    modport master (
        output acc_en, opcode, op_rdy, acc_data_in,
        input  acc_out, busy, op_done, flag_z, flag_n, flag_c, flag_v, illegal_op
    );

    modport slave (
        input  acc_en, opcode, op_rdy, acc_data_in,
        output acc_out, busy, op_done, flag_z, flag_n, flag_c, flag_v, illegal_op
    );
endinterface

`default_nettype wire

// File: rtl/acc_alu.sv
// ============================================================================
// Module  : acc_alu
// Brief   : Combinational accumulator ALU; shifts are a single bit per call.
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc_alu
    import acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SAT_EN = 0
) (
    input  alu_op_e           op_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] operand_i,
    output logic [DATA_W-1:0] res_o,
    output logic              c_o,
    output logic              v_o
);
    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] b;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;

    assign b    = ((op_i == ALU_INC) || (op_i == ALU_DEC)) ? DATA_W'(1) : operand_i;
    assign sum  = {1'b0, acc_i} + {1'b0, b};
    assign diff = {1'b0, acc_i} - {1'b0, b};

    always_comb begin
        res_o = acc_i;
        c_o   = 1'b0;
        v_o   = 1'b0;
        case (op_i)
            ALU_LDA: res_o = operand_i;
            ALU_INC, ALU_ADD: begin
                res_o = sum[DATA_W-1:0];
                c_o   = sum[DATA_W];
                v_o   = (acc_i[MSB] == b[MSB]) && (sum[MSB] != acc_i[MSB]);
                if ((SAT_EN != 0) && sum[DATA_W]) res_o = '1;
            end
            ALU_DEC, ALU_SUB: begin
                res_o = diff[DATA_W-1:0];
                c_o   = diff[DATA_W];
                v_o   = (acc_i[MSB] != b[MSB]) && (diff[MSB] != acc_i[MSB]);
                if ((SAT_EN != 0) && diff[DATA_W]) res_o = '0;
            end
            ALU_AND: res_o = acc_i & operand_i;
            ALU_OR:  res_o = acc_i | operand_i;
            ALU_XOR: res_o = acc_i ^ operand_i;
            ALU_SHL: begin
                res_o = {acc_i[DATA_W-2:0], 1'b0};
                c_o   = acc_i[MSB];
            end
            ALU_SHR: begin
                res_o = {1'b0, acc_i[DATA_W-1:1]};
                c_o   = acc_i[0];
            end
            ALU_CLR: res_o = '0;
            default: ;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/acc_unit.sv
// ============================================================================
// Module  : acc_unit
// Brief   : Accumulator with flags, optional saturation and multi-cycle shifts.
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc_unit
    import acc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int OPCODE_W = 24,
    parameter int SAT_EN   = 0,
    parameter int SHAMT_W  = $clog2(DATA_W)
) (
    input  logic clk,
    input  logic acc_rst_n,
    acc_if.slave bus
);
    state_e              state_q;
    alu_op_e             shop_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [DATA_W-1:0]   acc_q;
    logic [FLAG_W-1:0]   flags_q;
    logic                busy_q;
    logic                done_q;
    logic                ill_q;

    alu_op_e             op_dec;
    alu_op_e             alu_op;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                alu_v;
    logic [SHAMT_W-1:0]  shamt;

    assign op_dec = decode_op(32'(bus.opcode));
    assign alu_op = (state_q == ST_SHIFT) ? shop_q : op_dec;
    assign shamt  = bus.acc_data_in[SHAMT_W-1:0];

    acc_alu #(
        .DATA_W (DATA_W),
        .SAT_EN (SAT_EN)
    ) u_alu (
        .op_i      (alu_op),
        .acc_i     (acc_q),
        .operand_i (bus.acc_data_in),
        .res_o     (alu_res),
        .c_o       (alu_c),
        .v_o       (alu_v)
    );

    always_ff @(posedge clk or negedge acc_rst_n) begin
        if (!acc_rst_n) begin
            state_q <= ST_IDLE;
            shop_q  <= ALU_SHL;
            cnt_q   <= '0;
            acc_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.op_rdy && bus.acc_en) begin
                        if (op_dec == ALU_ILL) begin
                            ill_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else if (is_shift(op_dec)) begin
                            ill_q <= 1'b0;
                            if (shamt == '0) begin
                                flags_q[FLAG_C] <= 1'b0;
                                flags_q[FLAG_Z] <= (acc_q == '0);
                                flags_q[FLAG_N] <= acc_q[DATA_W-1];
                                done_q          <= 1'b1;
                            end else begin
                                shop_q  <= op_dec;
                                cnt_q   <= shamt;
                                state_q <= ST_SHIFT;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            ill_q           <= 1'b0;
                            acc_q           <= alu_res;
                            flags_q[FLAG_C] <= alu_c;
                            flags_q[FLAG_V] <= alu_v;
                            flags_q[FLAG_Z] <= (alu_res == '0);
                            flags_q[FLAG_N] <= alu_res[DATA_W-1];
                            done_q          <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    // z/n only settle at completion; v is left untouched by shifts.
                    if (bus.acc_en) begin
                        acc_q           <= alu_res;
                        flags_q[FLAG_C] <= alu_c;
                        cnt_q           <= cnt_q - SHAMT_W'(1);
                        if (cnt_q == SHAMT_W'(1)) begin
                            state_q         <= ST_IDLE;
                            busy_q          <= 1'b0;
                            done_q          <= 1'b1;
                            flags_q[FLAG_Z] <= (alu_res == '0);
                            flags_q[FLAG_N] <= alu_res[DATA_W-1];
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.acc_out    = acc_q;
    assign bus.busy       = busy_q;
    assign bus.op_done    = done_q;
    assign bus.flag_z     = flags_q[FLAG_Z];
    assign bus.flag_n     = flags_q[FLAG_N];
    assign bus.flag_c     = flags_q[FLAG_C];
    assign bus.flag_v     = flags_q[FLAG_V];
    assign bus.illegal_op = ill_q;
endmodule

`default_nettype wire

// File: tb/tb_acc_unit.sv
// ============================================================================
// Module  : tb_acc_unit
// Brief   : Directed bench driving a wrap-around and a saturating acc_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_acc_unit;
    import acc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    acc_if #(.DATA_W(8), .OPCODE_W(24)) bus0 ();
    acc_if #(.DATA_W(8), .OPCODE_W(24)) bus1 ();

    acc_unit #(.DATA_W(8), .OPCODE_W(24), .SAT_EN(0)) dut0 (
        .clk       (clk),
        .acc_rst_n (rst_n),
        .bus       (bus0.slave)
    );

    acc_unit #(.DATA_W(8), .OPCODE_W(24), .SAT_EN(1)) dut1 (
        .clk       (clk),
        .acc_rst_n (rst_n),
        .bus       (bus1.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic [23:0] code, input logic [7:0] data, input logic en);
        bus0.op_rdy = rdy;  bus0.opcode = code;  bus0.acc_data_in = data;  bus0.acc_en = en;
        bus1.op_rdy = rdy;  bus1.opcode = code;  bus1.acc_data_in = data;  bus1.acc_en = en;
    endtask

    // Single-cycle op; returns at the negedge where the result and op_done are visible.
    task automatic do_op(input string tag, input logic [23:0] code, input logic [7:0] data);
        @(negedge clk);
        drive(1'b1, code, data, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, code, data, 1'b1);
        check({tag, "_done"}, 32'(bus0.op_done), 32'd1);
    endtask

    task automatic shift_op(input logic [23:0] code, input logic [7:0] amt, input int stall_at,
                            input int stall_len, input bit poke,
                            output int lat, output int busy_cnt, output int done_cnt);
        @(negedge clk);
        drive(1'b1, code, amt, 1'b1);
        @(posedge clk);
        lat = -1;  busy_cnt = 0;  done_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus0.busy === 1'b1) busy_cnt++;
            if (bus0.op_done === 1'b1) begin
                done_cnt++;
                if (lat < 0) lat = i - 1;
            end
            drive(poke && (bus0.busy === 1'b1), OP_LDA, 8'h55,
                  !(i >= stall_at && i < stall_at + stall_len));
            @(posedge clk);
        end
        @(negedge clk);
        drive(1'b0, OP_LDA, 8'h00, 1'b1);
    endtask

    int lat, bcnt, dcnt;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 24'h0, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        check("rst_acc",  32'(bus0.acc_out), 32'h0);
        check("rst_flag", {28'h0, bus0.flag_z, bus0.flag_n, bus0.flag_c, bus0.flag_v}, 32'h0);
        check("rst_busy", 32'(bus0.busy), 32'h0);
        check("rst_done", 32'(bus0.op_done), 32'h0);
        check("rst_ill",  32'(bus0.illegal_op), 32'h0);
        rst_n = 1'b1;

        do_op("lda7f", OP_LDA, 8'h7F);
        check("lda7f_acc", 32'(bus0.acc_out), 32'h7F);
        check("lda7f_zn",  {30'h0, bus0.flag_z, bus0.flag_n}, 32'h0);
        @(negedge clk);
        check("lda7f_pulse_end", 32'(bus0.op_done), 32'h0);

        do_op("add", OP_ADD, 8'h01);
        check("add_acc",  32'(bus0.acc_out), 32'h80);
        check("add_nvc",  {29'h0, bus0.flag_n, bus0.flag_v, bus0.flag_c}, 32'b110);

        do_op("ldaff", OP_LDA, 8'hFF);
        do_op("inc", OP_INC, 8'h00);
        check("inc_wrap_acc", 32'(bus0.acc_out), 32'h00);
        check("inc_wrap_zc",  {30'h0, bus0.flag_z, bus0.flag_c}, 32'b11);
        check("inc_sat_acc",  32'(bus1.acc_out), 32'hFF);
        check("inc_sat_c",    32'(bus1.flag_c), 32'h1);

        do_op("dec", OP_DEC, 8'h00);
        check("dec_acc", 32'(bus0.acc_out), 32'hFF);
        check("dec_cn",  {30'h0, bus0.flag_c, bus0.flag_n}, 32'b11);

        do_op("lda03", OP_LDA, 8'h03);
        do_op("sub", OP_SUB, 8'h05);
        check("sub_sat_acc",  32'(bus1.acc_out), 32'h00);
        check("sub_sat_c",    32'(bus1.flag_c), 32'h1);
        check("sub_wrap_acc", 32'(bus0.acc_out), 32'hFE);

        do_op("lda81", OP_LDA, 8'h81);
        shift_op(OP_SHL, 8'd3, 0, 0, 1'b1, lat, bcnt, dcnt);
        check("shl3_lat",  32'(lat), 32'd3);
        check("shl3_busy", 32'(bcnt), 32'd3);
        check("shl3_done", 32'(dcnt), 32'd1);
        check("shl3_acc",  32'(bus0.acc_out), 32'h08);
        check("shl3_c",    32'(bus0.flag_c), 32'h0);

        do_op("lda81b", OP_LDA, 8'h81);
        shift_op(OP_SHL, 8'd3, 2, 2, 1'b0, lat, bcnt, dcnt);
        check("stall_lat",  32'(lat), 32'd5);
        check("stall_busy", 32'(bcnt), 32'd5);
        check("stall_acc",  32'(bus0.acc_out), 32'h08);

        shift_op(OP_SHR, 8'd4, 0, 0, 1'b0, lat, bcnt, dcnt);
        check("shr4_lat", 32'(lat), 32'd4);
        check("shr4_acc", 32'(bus0.acc_out), 32'h00);
        check("shr4_zc",  {30'h0, bus0.flag_z, bus0.flag_c}, 32'b11);

        do_op("shl0", OP_SHL, 8'h00);
        check("shl0_acc",  32'(bus0.acc_out), 32'h00);
        check("shl0_zc",   {30'h0, bus0.flag_z, bus0.flag_c}, 32'b10);
        check("shl0_busy", 32'(bus0.busy), 32'h0);

        do_op("lda5a", OP_LDA, 8'h5A);
        do_op("ill", 24'h123456, 8'hFF);
        check("ill_acc",  32'(bus0.acc_out), 32'h5A);
        check("ill_flag", 32'(bus0.illegal_op), 32'h1);
        check("ill_zc",   {30'h0, bus0.flag_z, bus0.flag_c}, 32'b00);
        do_op("clr", OP_CLR, 8'h33);
        check("clr_acc",  32'(bus0.acc_out), 32'h00);
        check("clr_z",    32'(bus0.flag_z), 32'h1);
        check("clr_ill",  32'(bus0.illegal_op), 32'h0);

        do_op("lda81c", OP_LDA, 8'h81);
        @(negedge clk);
        drive(1'b1, OP_SHL, 8'd5, 1'b1);
        @(posedge clk);
        #1 drive(1'b0, OP_LDA, 8'h00, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_acc",  32'(bus0.acc_out), 32'h00);
        check("arst_busy", 32'(bus0.busy), 32'h0);
        check("arst_c",    32'(bus0.flag_c), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus0.op_done !== 1'b0) dcnt++;
        end
        check("arst_no_done", 32'(dcnt), 32'd0);
        check("arst_idle",    32'(bus0.busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
